ama_riscv_mem_arb: RTL and testbench

AMA_RISCV_MEM_ARB -- requirements
Module: ama_riscv_mem_arb

---
 rtl/ama_riscv_mem_arb_pkg.sv | 20 ++
 rtl/ama_riscv_rr_arb2.sv | 23 ++
 rtl/ama_riscv_mem_arb.sv | 131 +++++++++++++
 tb/tb_ama_riscv_mem_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_mem_arb_pkg.sv
// Shared types and constants for the icache/dcache memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ama_riscv_mem_arb_pkg;

    localparam int ARB_LINE_W = 128;
    localparam int ARB_CNT_W  = 16;

    typedef enum logic {
        ARB_IC = 1'b0,
        ARB_DC = 1'b1
    } arb_src_t;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_MREQ = 2'd1,
        ARB_MRSP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ama_riscv_rr_arb2.sv
// Two-way round-robin pick: bit 0 = icache, bit 1 = dcache, one-hot grant out.
// Latency: combinational.
// Backpressure: none; the grant is only a suggestion until the caller accepts it.
module ama_riscv_rr_arb2
    import ama_riscv_mem_arb_pkg::*;
(
    input  logic [1:0] i_valid,
    input  arb_src_t   i_last_gnt,
    output logic [1:0] o_gnt
);

    // Single requester wins outright; on a tie the one not served last wins.
    always_comb begin
        o_gnt = 2'b00;
        case (i_valid)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = (i_last_gnt == ARB_IC) ? 2'b10 : 2'b01;
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/ama_riscv_mem_arb.sv
// Arbitrates icache refills and dcache refill/writeback onto one memory port, one transaction at a time.
// Latency: 3 cycles minimum per transaction (accept, memory request, memory response).
// Backpressure: req_ready only in IDLE; mem_req held stable until mem_req_ready; response passed through the same cycle.
module ama_riscv_mem_arb
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = ARB_LINE_W
)(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 ic_req_valid,
    output logic                 ic_req_ready,
    input  logic [ADDR_W-1:0]    ic_req_addr,
    output logic                 ic_rsp_valid,
    output logic [LINE_W-1:0]    ic_rsp_data,

    input  logic                 dc_req_valid,
    output logic                 dc_req_ready,
    input  logic [ADDR_W-1:0]    dc_req_addr,
    input  logic                 dc_req_we,
    input  logic [LINE_W-1:0]    dc_req_wdata,
    output logic                 dc_rsp_valid,
    output logic [LINE_W-1:0]    dc_rsp_data,

    output logic                 mem_req_valid,
    input  logic                 mem_req_ready,
    output logic [ADDR_W-1:0]    mem_req_addr,
    output logic                 mem_req_we,
    output logic [LINE_W-1:0]    mem_req_wdata,
    input  logic                 mem_rsp_valid,
    output logic                 mem_rsp_ready,
    input  logic [LINE_W-1:0]    mem_rsp_data,

    output logic [ARB_CNT_W-1:0] gnt_cnt_ic,
    output logic [ARB_CNT_W-1:0] gnt_cnt_dc,
    output logic                 proto_err
);

    arb_state_t            r_state;
    arb_src_t              r_last_gnt;
    arb_src_t              r_src;
    logic [ADDR_W-1:0]     r_addr;
    logic                  r_we;
    logic [LINE_W-1:0]     r_wdata;
    logic [ARB_CNT_W-1:0]  r_cnt_ic;
    logic [ARB_CNT_W-1:0]  r_cnt_dc;
    logic                  r_proto_err;

    logic [1:0]            w_gnt;
    logic                  w_idle;
    logic                  w_rsp_fire;

    ama_riscv_rr_arb2 u_rr_arb2 (
        .i_valid    ({dc_req_valid, ic_req_valid}),
        .i_last_gnt (r_last_gnt),
        .o_gnt      (w_gnt)
    );

    // Handshake decode; ready is masked during reset so nothing is accepted while rst is high.
    always_comb begin
        w_idle        = (r_state == ARB_IDLE) && !rst;
        w_rsp_fire    = (r_state == ARB_MRSP) && mem_rsp_valid;

        ic_req_ready  = w_idle && w_gnt[0];
        dc_req_ready  = w_idle && w_gnt[1];

        mem_req_valid = (r_state == ARB_MREQ);
        mem_req_addr  = mem_req_valid ? r_addr  : '0;
        mem_req_we    = mem_req_valid && r_we;
        mem_req_wdata = mem_req_valid ? r_wdata : '0;
        mem_rsp_ready = (r_state == ARB_MRSP);

        ic_rsp_valid  = w_rsp_fire && (r_src == ARB_IC);
        dc_rsp_valid  = w_rsp_fire && (r_src == ARB_DC);
        ic_rsp_data   = ic_rsp_valid ? mem_rsp_data : '0;
        dc_rsp_data   = dc_rsp_valid ? mem_rsp_data : '0;

        gnt_cnt_ic    = r_cnt_ic;
        gnt_cnt_dc    = r_cnt_dc;
        proto_err     = r_proto_err;
    end

    // Transaction FSM: latch the winner, hold the memory request, complete on the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_last_gnt  <= ARB_IC;
            r_src       <= ARB_IC;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cnt_ic    <= '0;
            r_cnt_dc    <= '0;
            r_proto_err <= 1'b0;
        end else begin
            // A response outside MRSP has no owner: drop it and remember the violation.
            if (mem_rsp_valid && (r_state != ARB_MRSP))
                r_proto_err <= 1'b1;

            case (r_state)
                ARB_IDLE: begin
                    if (w_gnt != 2'b00) begin
                        r_src   <= w_gnt[1] ? ARB_DC : ARB_IC;
                        r_addr  <= w_gnt[1] ? dc_req_addr : ic_req_addr;
                        r_we    <= w_gnt[1] && dc_req_we;
                        r_wdata <= w_gnt[1] ? dc_req_wdata : '0;
                        r_state <= ARB_MREQ;
                    end
                end
                ARB_MREQ: begin
                    if (mem_req_ready)
                        r_state <= ARB_MRSP;
                end
                ARB_MRSP: begin
                    if (mem_rsp_valid) begin
                        if (r_src == ARB_IC)
                            r_cnt_ic <= r_cnt_ic + 16'd1;
                        else
                            r_cnt_dc <= r_cnt_dc + 16'd1;
                        r_last_gnt <= r_src;
                        r_state    <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ama_riscv_mem_arb.sv
// Directed self-checking bench for the icache/dcache memory arbiter.
// Latency: inputs driven on the falling edge, outputs checked 1 time unit later.
// Backpressure: memory ready/response driven explicitly per scenario.
module tb_ama_riscv_mem_arb;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ic_req_valid = 1'b0;
    logic         ic_req_ready;
    logic [31:0]  ic_req_addr = '0;
    logic         ic_rsp_valid;
    logic [127:0] ic_rsp_data;
    logic         dc_req_valid = 1'b0;
    logic         dc_req_ready;
    logic [31:0]  dc_req_addr = '0;
    logic         dc_req_we = 1'b0;
    logic [127:0] dc_req_wdata = '0;
    logic         dc_rsp_valid;
    logic [127:0] dc_rsp_data;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b0;
    logic [31:0]  mem_req_addr;
    logic         mem_req_we;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic         mem_rsp_ready;
    logic [127:0] mem_rsp_data = '0;
    logic [15:0]  gnt_cnt_ic;
    logic [15:0]  gnt_cnt_dc;
    logic         proto_err;

    int n_chk = 0;
    int n_err = 0;

    localparam logic [127:0] DATA_A5 = {16{8'hA5}};

    always #5 clk = ~clk;

    ama_riscv_mem_arb #(.ADDR_W(32), .LINE_W(128)) dut (
        .clk           (clk),
        .rst           (rst),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_req_addr   (ic_req_addr),
        .ic_rsp_valid  (ic_rsp_valid),
        .ic_rsp_data   (ic_rsp_data),
        .dc_req_valid  (dc_req_valid),
        .dc_req_ready  (dc_req_ready),
        .dc_req_addr   (dc_req_addr),
        .dc_req_we     (dc_req_we),
        .dc_req_wdata  (dc_req_wdata),
        .dc_rsp_valid  (dc_rsp_valid),
        .dc_rsp_data   (dc_rsp_data),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_ready (mem_rsp_ready),
        .mem_rsp_data  (mem_rsp_data),
        .gnt_cnt_ic    (gnt_cnt_ic),
        .gnt_cnt_dc    (gnt_cnt_dc),
        .proto_err     (proto_err)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulses reset across one rising edge; returns on a falling edge with rst low.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called on a falling edge in IDLE with the requester valids already set.
    // Walks accept -> MREQ (with stall) -> MRSP and checks every visible field.
    task automatic txn(input bit dc_win, input logic [31:0] a, input logic we,
                       input logic [127:0] wd, input int stall, input logic [127:0] rd);
        #1;
        check("win_ready",  dc_win ? dc_req_ready : ic_req_ready, 1'b1);
        check("lose_ready", dc_win ? ic_req_ready : dc_req_ready, 1'b0);
        @(negedge clk);
        if (dc_win) dc_req_valid = 1'b0; else ic_req_valid = 1'b0;
        for (int i = 0; i <= stall; i++) begin
            mem_req_ready = (i == stall);
            // Winner's inputs wander while its request is in flight; the latched copy must not.
            if (dc_win) begin
                dc_req_addr = ~a; dc_req_we = ~we; dc_req_wdata = ~wd;
            end else begin
                ic_req_addr = ~a;
            end
            #1;
            check("mreq_valid", mem_req_valid, 1'b1);
            check("mreq_addr",  mem_req_addr, a);
            check("mreq_we",    mem_req_we, we);
            check("mreq_wdata", mem_req_wdata, wd);
            check("mreq_rdy0",  {ic_req_ready, dc_req_ready}, 2'b00);
            if (i < stall) @(negedge clk);
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = rd;
        #1;
        check("mrsp_ready", mem_rsp_ready, 1'b1);
        check("mrsp_noreq", mem_req_valid, 1'b0);
        check("win_rsp_v",  dc_win ? dc_rsp_valid : ic_rsp_valid, 1'b1);
        check("win_rsp_d",  dc_win ? dc_rsp_data  : ic_rsp_data, rd);
        check("lose_rsp_v", dc_win ? ic_rsp_valid : dc_rsp_valid, 1'b0);
        check("lose_rsp_d", dc_win ? ic_rsp_data  : dc_rsp_data, 128'h0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check("rsp_single", {ic_rsp_valid, dc_rsp_valid}, 2'b00);
    endtask

    initial begin
        // Reset state, with an icache request already waiting.
        ic_req_valid = 1'b1;
        ic_req_addr  = 32'h40;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_ic_ready", ic_req_ready, 1'b0);
        check("rst_dc_ready", dc_req_ready, 1'b0);
        check("rst_mreq_v",   mem_req_valid, 1'b0);
        check("rst_mrsp_r",   mem_rsp_ready, 1'b0);
        check("rst_cnt_ic",   gnt_cnt_ic, 16'd0);
        check("rst_cnt_dc",   gnt_cnt_dc, 16'd0);
        check("rst_perr",     proto_err, 1'b0);

        // Single icache read granted on the first edge after reset release.
        @(negedge clk);
        rst = 1'b0;
        txn(1'b0, 32'h40, 1'b0, 128'h0, 0, DATA_A5);
        check("ic1_cnt_ic", gnt_cnt_ic, 16'd1);
        check("ic1_cnt_dc", gnt_cnt_dc, 16'd0);

        // Ties straight out of reset: DC, IC, DC, IC back to back.
        reset_dut();
        ic_req_valid = 1'b1; ic_req_addr = 32'h80;
        dc_req_valid = 1'b1; dc_req_addr = 32'h200; dc_req_we = 1'b0; dc_req_wdata = '0;
        txn(1'b1, 32'h200, 1'b0, 128'h0, 0, 128'h11);
        check("tie1_cnt_dc", gnt_cnt_dc, 16'd1);
        dc_req_valid = 1'b1; dc_req_addr = 32'h240; dc_req_we = 1'b0;
        ic_req_addr  = 32'h80;
        txn(1'b0, 32'h80, 1'b0, 128'h0, 0, 128'h22);
        ic_req_valid = 1'b1; ic_req_addr = 32'hC0;
        dc_req_addr  = 32'h240; dc_req_we = 1'b0; dc_req_wdata = '0;
        txn(1'b1, 32'h240, 1'b0, 128'h0, 0, 128'h33);
        dc_req_valid = 1'b1; dc_req_addr = 32'h280; dc_req_we = 1'b0;
        ic_req_addr  = 32'hC0;
        txn(1'b0, 32'hC0, 1'b0, 128'h0, 0, 128'h44);
        dc_req_valid = 1'b0;
        check("tie_cnt_ic", gnt_cnt_ic, 16'd2);
        check("tie_cnt_dc", gnt_cnt_dc, 16'd2);

        // Writeback with five cycles of memory backpressure.
        dc_req_valid = 1'b1; dc_req_addr = 32'h1000; dc_req_we = 1'b1; dc_req_wdata = 128'h1234;
        txn(1'b1, 32'h1000, 1'b1, 128'h1234, 5, 128'hACC);
        check("wb_cnt_dc", gnt_cnt_dc, 16'd3);
        check("wb_cnt_ic", gnt_cnt_ic, 16'd2);

        // Spurious response in IDLE.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 128'hDEAD;
        #1;
        check("spur_ic_v", ic_rsp_valid, 1'b0);
        check("spur_dc_v", dc_rsp_valid, 1'b0);
        check("spur_ic_d", ic_rsp_data, 128'h0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check("spur_perr", proto_err, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("spur_perr_sticky", proto_err, 1'b1);
        check("spur_cnt_ic", gnt_cnt_ic, 16'd2);
        check("spur_cnt_dc", gnt_cnt_dc, 16'd3);

        // Reset during MRSP abandons the transaction.
        @(negedge clk);
        ic_req_valid = 1'b1; ic_req_addr = 32'h300;
        @(negedge clk);
        ic_req_valid  = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        check("mid_mrsp_r", mem_rsp_ready, 1'b1);
        rst = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = DATA_A5;
        #1;
        check("mid_rst_mrsp_r", mem_rsp_ready, 1'b0);
        check("mid_rst_mreq_v", mem_req_valid, 1'b0);
        check("mid_rst_ic_v",   ic_rsp_valid, 1'b0);
        check("mid_rst_cnt_ic", gnt_cnt_ic, 16'd0);
        check("mid_rst_cnt_dc", gnt_cnt_dc, 16'd0);
        check("mid_rst_perr",   proto_err, 1'b0);
        @(negedge clk);
        #1;
        check("rst_rsp_perr", proto_err, 1'b0);
        mem_rsp_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        mem_rsp_valid = 1'b1;
        #1;
        check("late_rsp_ic_v", ic_rsp_valid, 1'b0);
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        #1;
        check("late_rsp_perr", proto_err, 1'b1);
        check("late_cnt_ic",   gnt_cnt_ic, 16'd0);

        // Counter wrap: preload to 0xFFFF, one more icache completion gives 0.
        reset_dut();
        force dut.r_cnt_ic = 16'hFFFF;
        #1;
        release dut.r_cnt_ic;
        check("wrap_preload", gnt_cnt_ic, 16'hFFFF);
        ic_req_valid = 1'b1; ic_req_addr = 32'h500;
        txn(1'b0, 32'h500, 1'b0, 128'h0, 0, 128'h55);
        check("wrap_cnt_ic", gnt_cnt_ic, 16'd0);
        check("wrap_cnt_dc", gnt_cnt_dc, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
